// File: rtl/ripple_adder_sequencer.sv
// Operand FIFO and sequencer around an external combinational ripple adder.
// Pops one operand triple, waits SETTLE_CYCLES for the carry chain, then holds the registered result for the consumer.
module ripple_adder_sequencer #(
    parameter int WIDTH         = 64,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_c_in,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_c_in,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_c_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_c_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * WIDTH + 1;
    localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    logic [SC_W-1:0]  r_settle;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_c_in;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_c_out;
    logic             r_out_valid;

    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    // in_ready depends only on the registered count, so a same-cycle pop never opens a full FIFO
    assign in_ready   = (r_count < CNT_W'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == ST_IDLE) && (r_count != CNT_W'(0));
    assign w_head     = r_mem[r_rd_ptr];

    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign add_c_in   = r_add_c_in;
    assign out_sum    = r_out_sum;
    assign out_c_out  = r_out_c_out;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = r_count;

    // Operand storage; contents are qualified by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_c_in};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer: drive adder, wait for settle, capture and hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_c_in  <= 1'b0;
            r_out_sum   <= '0;
            r_out_c_out <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_add_a    <= w_head[ENT_W-1 -: WIDTH];
                        r_add_b    <= w_head[WIDTH -: WIDTH];
                        r_add_c_in <= w_head[0];
                        r_settle   <= SC_W'(SETTLE_CYCLES);
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SC_W'(1)) begin
                        r_out_sum   <= add_sum;
                        r_out_c_out <= add_c_out;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_settle <= r_settle - SC_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_adder_sequencer.sv
// Bench for ripple_adder_sequencer: a behavioural adder feeds add_sum/add_c_out, and a scoreboard
// queue of a+b+c_in values is checked by a monitor whenever a result is handed over.
module tb_ripple_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_c_in;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_c_in;
    logic [63:0] add_sum;
    logic        add_c_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_c_out;
    logic        busy;
    logic [2:0]  fifo_count;

    logic        tb_corrupt;
    logic [64:0] w_adder;
    logic        last_push;
    logic [64:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    ripple_adder_sequencer #(.WIDTH(64), .DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c_in(in_c_in),
        .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
        .add_sum(add_sum), .add_c_out(add_c_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_c_out(out_c_out),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // External adder; tb_corrupt scrambles it to show the result register is held
    assign w_adder = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_c_in};
    assign {add_c_out, add_sum} = tb_corrupt ? ~w_adder : w_adder;

    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {64'd0, c};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sampled on the falling edge, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_push = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h with empty scoreboard at %0t",
                             {out_c_out, out_sum}, $time);
                end else begin
                    chk("result", {out_c_out, out_sum}, sb.pop_front());
                end
            end
            last_push = in_valid && in_ready;
            if (last_push) sb.push_back(model(in_a, in_b, in_c_in));
        end
    end

    task automatic wait_drain(input int max_cyc);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy || fifo_count != 3'd0) && k < max_cyc) begin
            tick();
            k++;
        end
        chk("drain_in_time", 65'(k < max_cyc), 65'd1);
    endtask

    task automatic wait_valid(input int max_cyc);
        int k;
        k = 0;
        while (!out_valid && k < max_cyc) begin
            tick();
            k++;
        end
        chk("valid_in_time", 65'(k < max_cyc), 65'd1);
    endtask

    task automatic push1(input logic [63:0] a, input logic [63:0] b, input logic c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c_in  = c;
    endtask

    initial begin
        logic [63:0] sa;
        logic [63:0] sbv;
        logic        seen;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c_in = 1'b0;
        out_ready = 1'b0; tb_corrupt = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 65'(in_ready), 65'd1);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_fifo_count", 65'(fifo_count), 65'd0);
        chk("rst_add_a", 65'(add_a), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        rst = 1'b0;
        tick();

        // Basic add with exact latency
        push1(64'hFF, 64'h12, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("basic_count_after_push", 65'(fifo_count), 65'd1);
        tick();
        chk("basic_pop_add_a", 65'(add_a), 65'hFF);
        chk("basic_pop_busy", 65'(busy), 65'd1);
        chk("basic_pop_count", 65'(fifo_count), 65'd0);
        tick();
        chk("basic_not_yet_valid", 65'(out_valid), 65'd0);
        tick();
        chk("basic_valid", 65'(out_valid), 65'd1);
        chk("basic_sum", {out_c_out, out_sum}, 65'h111);
        out_ready = 1'b1;
        tick();
        chk("basic_valid_cleared", 65'(out_valid), 65'd0);

        // Carry-out wrap cases
        push1(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        tick();
        push1(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        tick();
        in_valid = 1'b0;
        wait_drain(50);

        // Full FIFO under backpressure: six offered, five accepted
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push1({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", 65'(fifo_count), 65'd4);
        chk("full_in_ready", 65'(in_ready), 65'd0);
        chk("full_accepted", 65'(sb.size()), 65'd5);
        wait_valid(20);
        out_ready = 1'b1;
        wait_drain(100);

        // Simultaneous push and pop keeps count at 1
        push1(64'h1234, 64'h4321, 1'b1);
        tick();
        push1(64'hDEAD_BEEF, 64'hCAFE, 1'b0);
        tick();
        chk("pushpop_count", 65'(fifo_count), 65'd1);
        in_valid = 1'b0;
        wait_drain(50);

        // Random traffic with upstream hold rule; wraps pointers many times
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_push) begin
                case ($urandom_range(0, 3))
                    0:       push1(64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 1'($urandom));
                    default: push1({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
                endcase
                in_valid = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(200);

        // Reset one cycle after a pop with two entries queued
        out_ready = 1'b0;
        push1(64'h11, 64'h22, 1'b0);
        tick();
        push1(64'h33, 64'h44, 1'b0);
        tick();
        push1(64'h55, 64'h66, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("pre_reset_count", 65'(fifo_count), 65'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 65'(out_valid), 65'd0);
        chk("async_rst_add_a", 65'(add_a), 65'd0);
        chk("async_rst_count", 65'(fifo_count), 65'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("no_valid_after_reset", 65'(seen), 65'd0);

        // Result stall while the adder output changes
        out_ready = 1'b0;
        sa  = {$urandom, $urandom};
        sbv = {$urandom, $urandom};
        push1(sa, sbv, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_valid(20);
        tb_corrupt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 65'(out_valid), 65'd1);
            chk("stall_sum", {out_c_out, out_sum}, model(sa, sbv, 1'b1));
            chk("stall_add_a", 65'(add_a), 65'(sa));
            chk("stall_add_b", 65'(add_b), 65'(sbv));
        end
        tb_corrupt = 1'b0;
        out_ready = 1'b1;
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
